// File: rtl/m_proc_mc_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: opcodes, function
// codes, FSM encodings, and the immediate decoder / adder helpers.
package m_proc_mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // I/S/B/U/J immediate extraction, selected by opcode.
  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    logic [31:0] imm;
    imm = '0;
    case (ir[6:0])
      OP_I, OP_LOAD: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:     imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI:        imm = {ir[31:12], 12'b0};
      OP_JAL:        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:       imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

endpackage

// File: rtl/m_rf_rst.sv
// Register file with synchronous clear; index 0 always reads zero and ignores writes.
module m_rf_rst #(
  parameter int W  = 32,
  parameter int N  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] ra_idx,
  input  logic [AW-1:0] rb_idx,
  output logic [W-1:0]  ra_data,
  output logic [W-1:0]  rb_data
);

  logic [W-1:0] regs [N];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign ra_data = (ra_idx == '0) ? '0 : regs[ra_idx];
  assign rb_data = (rb_idx == '0) ? '0 : regs[rb_idx];

endmodule

// File: rtl/m_proc_mc.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB with internal
// instruction/data memories; halts on a write to HALT_REG or an illegal opcode.
module m_proc_mc
  import m_proc_mc_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          HALT_REG   = 30
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_halt,
  output logic        w_illegal,
  output logic [31:0] w_pc,
  output logic [2:0]  w_state,
  output logic        w_wb_en,
  output logic [4:0]  w_wb_idx,
  output logic [31:0] w_wb_data,
  output logic [31:0] w_retired
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, imm, aluout, mdr, retired;
  logic        illegal;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_data, rs2_data, alu_res, pc_plus4, pc_imm, wb_data;
  logic        legal, br_taken, is_load, is_store, is_branch, is_jal;
  logic        wb_en, dmem_we, halt;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign funct3    = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign funct7    = ir[31:25];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);

  assign pc_plus4 = add32(pc, 32'd4);
  assign pc_imm   = add32(pc, imm);
  assign br_taken = (funct3 == F3_BNE) ? (a != b) : (a == b);
  assign wb_data  = is_load ? mdr : aluout;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:           legal = (funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB));
      OP_I:           legal = (funct3 == F3_ADD);
      OP_LOAD:        legal = (funct3 == F3_LW);
      OP_STORE:       legal = (funct3 == F3_SW);
      OP_BRANCH:      legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      OP_JAL, OP_LUI: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = add32(a, imm);
    case (opcode)
      OP_R:    alu_res = (funct7 == F7_SUB) ? (a - b) : add32(a, b);
      OP_LUI:  alu_res = imm;
      OP_JAL:  alu_res = pc_plus4;
      default: alu_res = add32(a, imm);
    endcase
  end

  m_rf_rst #(.W(32), .N(32)) u_rf (
    .clk     (w_clk),
    .clr     (w_rst),
    .we      (wb_en),
    .wr_idx  (rd),
    .wr_data (wb_data),
    .ra_idx  (rs1),
    .rb_idx  (rs2),
    .ra_data (rs1_data),
    .rb_data (rs2_data)
  );

  // FSM: state register
  always_ff @(posedge w_clk) begin
    if (w_rst) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if (is_branch)              state_nxt = ST_FETCH;
        else if (is_load || is_store) state_nxt = ST_MEM;
        else                        state_nxt = ST_WB;
      end
      ST_MEM:    state_nxt = is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = (rd == 5'(HALT_REG)) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wb_en   = (state == ST_WB) && (rd != 5'd0);
    dmem_we = (state == ST_MEM) && is_store && !w_rst;
    halt    = (state == ST_HALT);
  end

  // Datapath registers; retirement is counted in the last cycle of each instruction.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      aluout  <= '0;
      mdr     <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: ir <= imem[pc[IW+1:2]];
        ST_DECODE: begin
          a   <= rs1_data;
          b   <= rs2_data;
          imm <= imm_gen(ir);
          if (!legal) illegal <= 1'b1;
        end
        ST_EXEC: begin
          aluout <= alu_res;
          pc     <= (is_jal || (is_branch && br_taken)) ? pc_imm : pc_plus4;
          if (is_branch) retired <= retired + 32'd1;
        end
        ST_MEM: begin
          if (is_load) mdr <= dmem[aluout[DW+1:2]];
          else         retired <= retired + 32'd1;
        end
        ST_WB:   retired <= retired + 32'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (dmem_we) dmem[aluout[DW+1:2]] <= b;
  end

  assign w_halt    = halt;
  assign w_illegal = illegal;
  assign w_pc      = pc;
  assign w_state   = state;
  assign w_wb_en   = wb_en;
  assign w_wb_idx  = rd;
  assign w_wb_data = wb_data;
  assign w_retired = retired;

endmodule

// File: tb/tb_m_proc_mc.sv
// Bench for m_proc_mc: directed programs from the test plan plus random programs
// checked against an instruction-level ISA model.
module tb_m_proc_mc;

  logic        w_clk, w_rst;
  logic        w_halt, w_illegal, w_wb_en;
  logic [31:0] w_pc, w_wb_data, w_retired;
  logic [2:0]  w_state;
  logic [4:0]  w_wb_idx;

  int n_checks = 0;
  int n_errors = 0;

  m_proc_mc #(.IMEM_WORDS(64), .DMEM_WORDS(64), .RESET_PC(32'h0), .HALT_REG(30)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_halt    (w_halt),
    .w_illegal (w_illegal),
    .w_pc      (w_pc),
    .w_state   (w_state),
    .w_wb_en   (w_wb_en),
    .w_wb_idx  (w_wb_idx),
    .w_wb_data (w_wb_data),
    .w_retired (w_retired)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef enum {K_ADDI, K_ADD, K_SUB, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_JAL} kind_t;
  typedef struct {
    kind_t       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  ins_t        prog [64];

  function automatic ins_t mk(kind_t k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    ins_t t;
    t.kind = k; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [31:0] enc(input ins_t in);
    logic [31:0] m, w;
    m = in.imm;
    w = '0;
    case (in.kind)
      K_ADDI: w = {m[11:0], in.rs1, 3'b000, in.rd, 7'b0010011};
      K_ADD:  w = {7'b0000000, in.rs2, in.rs1, 3'b000, in.rd, 7'b0110011};
      K_SUB:  w = {7'b0100000, in.rs2, in.rs1, 3'b000, in.rd, 7'b0110011};
      K_LUI:  w = {m[19:0], in.rd, 7'b0110111};
      K_LW:   w = {m[11:0], in.rs1, 3'b010, in.rd, 7'b0000011};
      K_SW:   w = {m[11:5], in.rs2, in.rs1, 3'b010, m[4:0], 7'b0100011};
      K_BEQ:  w = {m[12], m[10:5], in.rs2, in.rs1, 3'b000, m[4:1], m[11], 7'b1100011};
      K_BNE:  w = {m[12], m[10:5], in.rs2, in.rs1, 3'b001, m[4:1], m[11], 7'b1100011};
      K_JAL:  w = {m[20], m[10:1], m[11], m[19:12], in.rd, 7'b1101111};
      default: w = '0;
    endcase
    return w;
  endfunction

  // ISA-level model: one call executes one instruction and reports its timing and write-back.
  task automatic model_step(input ins_t in, output int lat, output bit wen, output logic [4:0] widx,
                            output logic [31:0] wdata, output bit halt);
    logic [31:0] s1, s2, res, addr, nxt;
    bit writes;
    s1 = m_rf[in.rs1]; s2 = m_rf[in.rs2];
    res = '0; writes = 1'b1; lat = 4; nxt = m_pc + 32'd4;
    case (in.kind)
      K_ADDI: res = s1 + in.imm;
      K_ADD:  res = s1 + s2;
      K_SUB:  res = s1 - s2;
      K_LUI:  res = in.imm << 12;
      K_LW:   begin addr = s1 + in.imm; res = m_dmem[(addr / 4) % 64]; lat = 5; end
      K_SW:   begin addr = s1 + in.imm; m_dmem[(addr / 4) % 64] = s2; writes = 1'b0; end
      K_BEQ:  begin lat = 3; writes = 1'b0; if (s1 == s2) nxt = m_pc + in.imm; end
      K_BNE:  begin lat = 3; writes = 1'b0; if (s1 != s2) nxt = m_pc + in.imm; end
      K_JAL:  begin res = m_pc + 32'd4; nxt = m_pc + in.imm; end
      default: ;
    endcase
    wen   = writes && (in.rd != 5'd0);
    widx  = in.rd;
    wdata = res;
    halt  = writes && (in.rd == 5'd30);
    if (wen) m_rf[in.rd] = res;
    m_pc = nxt;
    m_retired = m_retired + 32'd1;
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] words[$]);
    for (int i = 0; i < 64; i++) dut.imem[i] = '0;
    foreach (words[i]) dut.imem[i] = words[i];
  endtask

  task automatic test_reset();
    w_rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (w_pc !== 32'h0 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL reset_pc_state: got pc=%h state=%0d expected pc=0 state=0", w_pc, w_state);
    end
    n_checks++;
    if (w_halt !== 1'b0 || w_illegal !== 1'b0 || w_wb_en !== 1'b0 || w_retired !== 32'd0) begin
      n_errors++; $display("FAIL reset_flags: got halt=%b ill=%b wb=%b ret=%0d expected 0 0 0 0",
                           w_halt, w_illegal, w_wb_en, w_retired);
    end
    w_rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] q[$];
    q.push_back(enc(mk(K_ADDI, 1, 0, 0, 5)));
    q.push_back(enc(mk(K_ADDI, 2, 0, 0, 6)));
    q.push_back(enc(mk(K_ADD, 3, 1, 2, 0)));
    q.push_back(enc(mk(K_SW, 0, 0, 3, 8)));
    q.push_back(enc(mk(K_LW, 4, 0, 0, 8)));
    load_prog(q);
    do_reset();
    repeat (11) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd3 || w_wb_data !== 32'd11) begin
      n_errors++; $display("FAIL alu_add_wb: got en=%b idx=%0d data=%0d expected en=1 idx=3 data=11",
                           w_wb_en, w_wb_idx, w_wb_data);
    end
    tick();
    n_checks++;
    if (w_retired !== 32'd3 || w_pc !== 32'd12 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL alu_after_12: got ret=%0d pc=%0d state=%0d expected 3 12 0", w_retired, w_pc, w_state);
    end
  endtask

  task automatic test_mem();
    int wcnt;
    wcnt = 0;
    repeat (4) begin tick(); if (w_wb_en) wcnt++; end
    n_checks++;
    if (wcnt != 0 || w_retired !== 32'd4 || w_pc !== 32'd16 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL sw_4cyc: got wb=%0d ret=%0d pc=%0d state=%0d expected 0 4 16 0",
                           wcnt, w_retired, w_pc, w_state);
    end
    repeat (4) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd4 || w_wb_data !== 32'd11) begin
      n_errors++; $display("FAIL lw_wb: got en=%b idx=%0d data=%0d expected en=1 idx=4 data=11",
                           w_wb_en, w_wb_idx, w_wb_data);
    end
    tick();
    n_checks++;
    if (w_retired !== 32'd5 || w_pc !== 32'd20 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL lw_5cyc: got ret=%0d pc=%0d state=%0d expected 5 20 0", w_retired, w_pc, w_state);
    end
  endtask

  task automatic test_branch();
    logic [31:0] q[$];
    int wcnt;
    q.push_back(enc(mk(K_ADDI, 1, 0, 0, 5)));
    q.push_back(enc(mk(K_ADDI, 2, 0, 0, 6)));
    q.push_back(enc(mk(K_BNE, 0, 1, 2, 8)));
    q.push_back(32'h0);
    q.push_back(enc(mk(K_BEQ, 0, 1, 2, 8)));
    load_prog(q);
    do_reset();
    repeat (8) tick();
    wcnt = 0;
    repeat (2) begin tick(); if (w_wb_en) wcnt++; end
    n_checks++;
    if (w_state !== 3'd2) begin
      n_errors++; $display("FAIL bne_in_exec: got state=%0d expected 2", w_state);
    end
    tick(); if (w_wb_en) wcnt++;
    n_checks++;
    if (wcnt != 0 || w_pc !== 32'd16 || w_retired !== 32'd3 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL bne_taken: got wb=%0d pc=%0d ret=%0d state=%0d expected 0 16 3 0",
                           wcnt, w_pc, w_retired, w_state);
    end
    repeat (3) tick();
    n_checks++;
    if (w_pc !== 32'd20 || w_retired !== 32'd4 || w_state !== 3'd0) begin
      n_errors++; $display("FAIL beq_not_taken: got pc=%0d ret=%0d state=%0d expected 20 4 0", w_pc, w_retired, w_state);
    end
  endtask

  task automatic test_lui_jal();
    logic [31:0] q[$];
    q.push_back(enc(mk(K_LUI, 5, 0, 0, 32'h12345)));
    q.push_back(enc(mk(K_JAL, 6, 0, 0, 32'hFFFF_FFFC)));
    load_prog(q);
    do_reset();
    repeat (3) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd5 || w_wb_data !== 32'h1234_5000) begin
      n_errors++; $display("FAIL lui_wb: got en=%b idx=%0d data=%h expected en=1 idx=5 data=12345000",
                           w_wb_en, w_wb_idx, w_wb_data);
    end
    tick();
    repeat (3) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd6 || w_wb_data !== 32'd8) begin
      n_errors++; $display("FAIL jal_link: got en=%b idx=%0d data=%0d expected en=1 idx=6 data=8",
                           w_wb_en, w_wb_idx, w_wb_data);
    end
    tick();
    n_checks++;
    if (w_pc !== 32'd0 || w_retired !== 32'd2) begin
      n_errors++; $display("FAIL jal_target: got pc=%0d ret=%0d expected pc=0 ret=2", w_pc, w_retired);
    end
  endtask

  task automatic test_halt();
    logic [31:0] q[$];
    q.push_back(enc(mk(K_ADDI, 30, 0, 0, 1)));
    load_prog(q);
    do_reset();
    repeat (3) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd30 || w_wb_data !== 32'd1 || w_halt !== 1'b0) begin
      n_errors++; $display("FAIL halt_wb: got en=%b idx=%0d data=%0d halt=%b expected 1 30 1 0",
                           w_wb_en, w_wb_idx, w_wb_data, w_halt);
    end
    tick();
    n_checks++;
    if (w_halt !== 1'b1 || w_state !== 3'd5) begin
      n_errors++; $display("FAIL halt_entry: got halt=%b state=%0d expected halt=1 state=5", w_halt, w_state);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (w_pc !== 32'd4 || w_state !== 3'd5 || w_retired !== 32'd1 || w_wb_en !== 1'b0 ||
          w_halt !== 1'b1 || w_illegal !== 1'b0) begin
        n_errors++; $display("FAIL halt_frozen: cyc=%0d got pc=%0d state=%0d ret=%0d wb=%b halt=%b ill=%b expected 4 5 1 0 1 0",
                             c, w_pc, w_state, w_retired, w_wb_en, w_halt, w_illegal);
      end
    end
    do_reset();
    n_checks++;
    if (w_pc !== 32'd0 || w_halt !== 1'b0 || w_state !== 3'd0 || w_retired !== 32'd0) begin
      n_errors++; $display("FAIL halt_reset: got pc=%0d halt=%b state=%0d ret=%0d expected 0 0 0 0",
                           w_pc, w_halt, w_state, w_retired);
    end
    dut.imem[0] = enc(mk(K_ADD, 7, 30, 0, 0));
    repeat (3) tick();
    n_checks++;
    if (w_wb_en !== 1'b1 || w_wb_idx !== 5'd7 || w_wb_data !== 32'd0) begin
      n_errors++; $display("FAIL x30_cleared: got en=%b idx=%0d data=%0d expected en=1 idx=7 data=0",
                           w_wb_en, w_wb_idx, w_wb_data);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] q[$];
    q.push_back(32'h0);
    load_prog(q);
    do_reset();
    tick();
    tick();
    n_checks++;
    if (w_state !== 3'd5 || w_halt !== 1'b1 || w_illegal !== 1'b1 || w_retired !== 32'd0 || w_pc !== 32'd0) begin
      n_errors++; $display("FAIL illegal_halt: got state=%0d halt=%b ill=%b ret=%0d pc=%0d expected 5 1 1 0 0",
                           w_state, w_halt, w_illegal, w_retired, w_pc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    q.push_back(enc(mk(K_ADDI, 1, 0, 0, 5)));
    q.push_back(enc(mk(K_ADD, 2, 1, 1, 0)));
    load_prog(q);
    do_reset();
    repeat (6) tick();
    n_checks++;
    if (w_state !== 3'd2 || w_pc !== 32'd4) begin
      n_errors++; $display("FAIL mid_exec_reach: got state=%0d pc=%0d expected state=2 pc=4", w_state, w_pc);
    end
    do_reset();
    n_checks++;
    if (w_state !== 3'd0 || w_pc !== 32'd0 || w_retired !== 32'd0 || w_wb_en !== 1'b0) begin
      n_errors++; $display("FAIL mid_exec_reset: got state=%0d pc=%0d ret=%0d wb=%b expected 0 0 0 0",
                           w_state, w_pc, w_retired, w_wb_en);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n, steps, lat, cyc, wcnt;
      bit wen, hexp, done;
      logic [4:0] widx, gidx;
      logic [31:0] wdata, gdata, v;
      logic [11:0] t12;
      n = 24;
      for (int i = 0; i < n; i++) begin
        int k;
        k = $urandom_range(0, 7);
        if (k >= 6 && i > n - 2) k = 0;
        prog[i] = mk(K_ADDI, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0);
        case (k)
          0: begin t12 = 12'($urandom_range(0, 4095)); prog[i].imm = {{20{t12[11]}}, t12}; end
          1: prog[i].kind = K_ADD;
          2: prog[i].kind = K_SUB;
          3: begin prog[i].kind = K_LUI; prog[i].imm = 32'($urandom_range(0, 20'hFFFFF)); end
          4: begin prog[i].kind = K_LW; prog[i].imm = 32'($urandom_range(0, 255) * 4); end
          5: begin prog[i].kind = K_SW; prog[i].imm = 32'($urandom_range(0, 255) * 4); end
          6: begin prog[i].kind = K_BEQ; prog[i].imm = ($urandom_range(0, 1) != 0) ? 32'd8 : 32'd4; end
          default: begin prog[i].kind = K_BNE; prog[i].imm = ($urandom_range(0, 1) != 0) ? 32'd8 : 32'd4; end
        endcase
      end
      t12 = 12'($urandom_range(0, 4095));
      prog[n] = mk(K_ADDI, 30, 5'($urandom_range(0, 7)), 0, {{20{t12[11]}}, t12});
      for (int i = 0; i < 64; i++) dut.imem[i] = '0;
      for (int i = 0; i <= n; i++) dut.imem[i] = enc(prog[i]);
      for (int i = 0; i < 64; i++) begin v = $urandom; dut.dmem[i] = v; m_dmem[i] = v; end
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_pc = '0;
      m_retired = '0;
      do_reset();
      done = 1'b0;
      steps = 0;
      while (!done && steps < 100) begin
        model_step(prog[m_pc[7:2]], lat, wen, widx, wdata, hexp);
        cyc = 0; wcnt = 0; gidx = '0; gdata = '0;
        do begin
          tick();
          cyc++;
          if (w_wb_en) begin wcnt++; gidx = w_wb_idx; gdata = w_wb_data; end
        end while (w_state != 3'd0 && w_state != 3'd5 && cyc < 12);
        n_checks++;
        if (cyc != lat || wcnt != int'(wen)) begin
          n_errors++; $display("FAIL rand_timing: run=%0d step=%0d got cyc=%0d wbs=%0d expected cyc=%0d wbs=%0d",
                               r, steps, cyc, wcnt, lat, int'(wen));
        end
        if (wen) begin
          n_checks++;
          if (gidx !== widx || gdata !== wdata) begin
            n_errors++; $display("FAIL rand_wb: run=%0d step=%0d got idx=%0d data=%h expected idx=%0d data=%h",
                                 r, steps, gidx, gdata, widx, wdata);
          end
        end
        n_checks++;
        if (w_pc !== m_pc || w_retired !== m_retired || w_state !== (hexp ? 3'd5 : 3'd0)) begin
          n_errors++; $display("FAIL rand_arch: run=%0d step=%0d got pc=%h ret=%0d state=%0d expected pc=%h ret=%0d halt=%b",
                               r, steps, w_pc, w_retired, w_state, m_pc, m_retired, hexp);
        end
        done = hexp;
        steps++;
      end
      n_checks++;
      if (!done || w_halt !== 1'b1 || w_illegal !== 1'b0) begin
        n_errors++; $display("FAIL rand_end: run=%0d got done=%b halt=%b ill=%b expected 1 1 0",
                             r, done, w_halt, w_illegal);
      end
    end
  endtask

  initial begin
    w_rst = 1'b1;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_lui_jal();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_proc_mc.md
Name: m_proc_mc

Overview:
- Multicycle RV32I-subset processor; the next generation of the single-cycle adder-only core in cpu.v.
- Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine and skips the states it does not need.
- Instruction memory, data memory and register file are internal, with memory depths parametrised.
- Halt is an output flag instead of a simulator $finish, so benches and parent blocks can observe it.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).
- RESET_PC, 32'h0, PC value loaded on reset.
- HALT_REG, 30, destination register whose write-back halts the core.

Ports:
- w_clk  in  1  clock, all state updates on posedge.
- w_rst  in  1  synchronous active-high reset.
- w_halt  out  1  core halted, sticky until reset.
- w_illegal  out  1  halted because of an unsupported opcode, sticky.
- w_pc  out  32  current PC.
- w_state  out  3  current FSM state encoding.
- w_wb_en  out  1  register write this cycle.
- w_wb_idx  out  5  register write index.
- w_wb_data  out  32  register write data.
- w_retired  out  32  count of completed instructions.

Behaviour:
- Reset (w_rst=1 at posedge):
  - PC=RESET_PC, state=FETCH.
  - x1..x31 := 0; IR/A/B/ALUOUT/MDR := 0.
  - w_halt=0, w_illegal=0, w_retired=0, w_wb_en=0.
  - Memories are not cleared; they keep initial or loaded contents.
  - Reset overrides every state, including HALT and mid-instruction.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
- FETCH: IR := imem[PC[log2(IMEM_WORDS)+1:2]]. Index wraps modulo depth; PC[1:0] ignored.
- DECODE:
  - A := RF[rs1], B := RF[rs2]; x0 reads 0.
  - IMM generated with the I/S/B/U/J rules of the existing immediate decoder.
  - Unsupported opcode -> HALT with w_illegal=1; w_retired not incremented.
- EXEC:
  - ADD/SUB (opcode 0110011, funct3=000, funct7 0000000/0100000): ALUOUT = A±B.
  - ADDI (0010011, funct3=000): ALUOUT = A+IMM.
  - LW/SW: ALUOUT = A+IMM.
  - LUI: ALUOUT = IMM.
  - JAL: ALUOUT = PC+4, PC := PC+IMM.
  - BEQ/BNE: PC := taken ? PC+IMM : PC+4, then FETCH. Branches retire here.
  - All other instructions set PC := PC+4 in EXEC.
- MEM:
  - LW: MDR := dmem[ALUOUT index], then WB.
  - SW: dmem[index] := B, then FETCH; SW retires here.
  - DMEM index wraps modulo DMEM_WORDS.
- WB:
  - w_wb_en=1 for exactly this cycle when rd≠0; writes ALUOUT, or MDR for LW.
  - rd=0 write is suppressed (w_wb_en=0) but the instruction still retires.
  - rd==HALT_REG write -> HALT after the write completes.
  - Otherwise next state is FETCH.
- Latency:
  - Branch: 3 cycles.
  - ALU/LUI/JAL/SW: 4 cycles.
  - LW: 5 cycles.
- w_retired increments by 1 in the final cycle of each completed instruction, wrapping at 2^32.
- Arithmetic: 32-bit modulo, overflow ignored; branch compare uses full 32 bits.
- HALT: no state changes except on reset; w_wb_en=0.

Decomposition:
- Shared package holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - funct3/funct7 constants;
  - FSM state encodings.
- Reuse the existing immediate generator and adder for IMM and PC+4.
- One natural new sub-module: m_rf_rst, a parametrised register file with synchronous clear and x0 hardwiring.

Test Plan:
- Reset, then `addi x1,x0,5; addi x2,x0,6; add x3,x1,x2` -> x3=11, w_retired=3 after 12 cycles, PC=12.
- `sw x3,8(x0); lw x4,8(x0)` -> dmem[2]=11, x4=11; load takes 5 cycles, store 4.
- `bne x1,x2,+8` with x1≠x2 -> PC jumps by 8 after 3 cycles; the same test with BEQ is not taken -> PC+4.
- `lui x5,0x12345; jal x6,-4` -> x5=0x12345000, x6=PC+4, PC=old PC-4.
- `addi x30,x0,1` -> w_halt=1 on the cycle after WB, outputs frozen for 10 cycles; then pulse w_rst -> PC=0, w_halt=0, x30=0.
- Word 0x00000000 at PC=0 -> HALT with w_illegal=1, w_retired=0; w_rst asserted mid-EXEC of an ADD -> no write-back, state=FETCH.
